// File: rtl/mc_wr_fifo_pkg.sv
// Shared definitions for the memory-controller write-data FIFO: beat layout
// and burst FSM state encodings.
package mc_wr_fifo_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int BEAT_W = MASK_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mc_wr_fifo_ptr.sv
// Pointer, level, full/empty and sticky error bookkeeping for mc_wr_fifo.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mc_wr_fifo_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic          re,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW:0] PTR_STEP = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Flags derive only from registered pointers, so we/re never reach them combinationally.
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  assign push = we & (~full | re);
  assign pop  = re & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_STEP;
      if (pop)  rd_ptr <= rd_ptr + PTR_STEP;
      ovf <= ovf | (we & ~push);
      udf <= udf | (re & empty);
    end
  end

endmodule

// File: rtl/mc_wr_fifo.sv
// Host-to-memory write-data FIFO with a burst-ready FSM for the sequencer.
// Optional macro MC_WR_FIFO_PARITY_EN adds per-entry even parity and par_err.
module mc_wr_fifo
  import mc_wr_fifo_pkg::*;
#(
  parameter int AW        = 2,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [BEAT_W-1:0] din,
  input  logic              we,
  output logic              full,
  input  logic              re,
  output logic [BEAT_W-1:0] dout,
  output logic              empty,
  output logic [AW:0]       level,
  input  logic              flush,
  output logic              burst_rdy,
  output logic [AW:0]       burst_beats,
  output logic              ovf,
  output logic              udf
`ifdef MC_WR_FIFO_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] BL        = BURST_LEN[AW:0];
  localparam logic [AW:0] LAST_BEAT = {{AW{1'b0}}, 1'b1};
`ifdef MC_WR_FIFO_PARITY_EN
  localparam int          MEM_W     = BEAT_W + 1;
`else
  localparam int          MEM_W     = BEAT_W;
`endif

  logic          push;
  logic          pop;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  mc_wr_fifo_ptr #(.AW(AW)) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .we      (we),
    .re      (re),
    .push    (push),
    .pop     (pop),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf)
  );

  // ---------------------------------------------------------------- storage
  logic [MEM_W-1:0] mem [DEPTH];
  logic [MEM_W-1:0] head;

  // NOTE: the storage array has no reset; only pointers define validity, so
  // clearing it would just add reset fan-out to every entry.
  always_ff @(posedge clk) begin
`ifdef MC_WR_FIFO_PARITY_EN
    if (push) mem[wr_addr] <= {^din, din};
`else
    if (push) mem[wr_addr] <= din;
`endif
  end

  assign head = mem[rd_addr];
  assign dout = head[BEAT_W-1:0];

`ifdef MC_WR_FIFO_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      par_err <= 1'b0;
    else if (clr) par_err <= 1'b0;
    else          par_err <= par_err | (pop & (head[BEAT_W] != ^dout));
  end
`endif

  // ------------------------------------------------------------- burst FSM
  state_t      state;
  state_t      state_nxt;
  logic        rdy_nxt;
  logic        burst_start;
  logic        flush_pend;
  logic [AW:0] beats_left;
  logic [AW:0] start_beats;

  assign burst_start = (level >= BL) || ((flush_pend | flush) && (level != '0));
  assign start_beats = (level < BL) ? level : BL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      burst_rdy   <= 1'b0;
      burst_beats <= '0;
      beats_left  <= '0;
      flush_pend  <= 1'b0;
    end else if (clr) begin
      state       <= IDLE;
      burst_rdy   <= 1'b0;
      burst_beats <= '0;
      beats_left  <= '0;
      flush_pend  <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_rdy <= rdy_nxt;
      if (state == IDLE && state_nxt == READY) begin
        burst_beats <= start_beats;
        beats_left  <= start_beats;
      end else if (pop && state != IDLE && beats_left != '0) begin
        beats_left <= beats_left - LAST_BEAT;
      end
      // A flush arriving as READY is left still counts toward the next burst.
      if (state == READY && state_nxt != READY) flush_pend <= flush;
      else if (flush)                           flush_pend <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (burst_start) state_nxt = READY;
      READY:   if (pop) state_nxt = (beats_left == LAST_BEAT) ? IDLE : DRAIN;
      DRAIN:   if (pop && beats_left == LAST_BEAT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // burst_rdy rises the cycle after READY is entered and drops with the first pop.
  always_comb begin
    rdy_nxt = (state == READY) && (state_nxt == READY);
  end

endmodule

// File: doc/mc_wr_fifo.md
Name: mc_wr_fifo

Overview:
Write-data buffer for the memory controller's host-to-memory path. The host side pushes 36-bit write beats, each 32 data bits plus a 4-bit byte mask. The memory-side sequencer pops them in bursts. The block tracks occupancy, full/empty and error flags, and runs a burst-ready FSM. The FSM tells the sequencer when a complete burst, or a flushed partial burst, is available to drain.

Parameters:
AW, 2, address width; DEPTH = 2**AW entries (4 default, legal 2..16).
BURST_LEN, 4, beats per full burst; 1..DEPTH.

Ports:
clk  in  1  clock
rst  in  1  reset
clr  in  1  synchronous clear of pointers, level, FSM and flags
din  in  36  write beat {mask[3:0], data[31:0]}
we  in  1  push request
full  out  1  no free entry
re  in  1  pop request (memory side)
dout  out  36  head entry, first-word-fall-through
empty  out  1  no valid entry
level  out  AW+1  occupied entries, 0..DEPTH
flush  in  1  pulse: drain remaining entries even if fewer than BURST_LEN
burst_rdy  out  1  burst available; sequencer may start popping
burst_beats  out  AW+1  beat count of the burst that is ready or draining
ovf  out  1  sticky: push attempted while full
udf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset rst, asynchronous, active-high; clock clk. All state is on posedge clk.
- Reset/clr values:
  - Pointers, level, burst_beats: 0.
  - empty=1, full=0, burst_rdy=0, ovf=0, udf=0.
  - FSM=IDLE, flush_pend=0.
  - Storage is not reset, so dout is undefined until the first write.
  - clr has priority over we/re/flush in the same cycle. clr does not touch storage.
- Pointers are binary AW+1 bits, with the extra bit used as a wrap flag.
  - full = addresses equal and wrap bits differ.
  - empty = pointers equal.
  - level = wr_ptr - rd_ptr, taken mod 2**(AW+1).
- Push: accepted when we & (!full | re).
  - A simultaneous push and pop while full is legal: the pop frees the slot in the same cycle.
  - A rejected push sets ovf.
- Pop: accepted when re & !empty. re while empty sets udf; a simultaneous we is still accepted.
- Accepted operations change level as follows: push only +1, pop only -1, both 0.
- dout = mem[rd_ptr] combinationally. A written entry becomes visible on dout the cycle after it is pushed.
- flush_pend is set by flush and cleared when the FSM leaves READY for DRAIN.
- FSM states:
  - IDLE: go to READY when level >= BURST_LEN, or when (flush_pend | flush) & level != 0.
    - On that transition, burst_beats = min(level, BURST_LEN).
  - READY: burst_rdy=1 (registered, asserted the cycle after entry). The first accepted pop moves the FSM to DRAIN and decrements the beat counter.
  - DRAIN: burst_rdy=0. Each accepted pop decrements the counter. When the last beat is popped the FSM returns to IDLE, and the next burst is re-evaluated the following cycle.
  - Pushes during READY/DRAIN do not change burst_beats.
- Popping more than burst_beats is not protocol-legal. Extra pops are still served if the FIFO is not empty.
- Register boundaries: level/full/empty update the cycle after the op. There is no combinational path from we/re to full/empty.

Optional Feature:
MC_WR_FIFO_PARITY_EN:
- Defined:
  - Each entry stores an extra even-parity bit over din[35:0], computed on write.
  - A new output par_err (1 bit, sticky) is added. It is set when an accepted pop reads an entry whose stored parity mismatches the parity recomputed from dout.
  - par_err is cleared by rst/clr.
- Undefined: no parity storage and no par_err port.

Decomposition:
- Shared package mc_wr_fifo_pkg holds:
  - FSM state encodings: IDLE=2'd0, READY=2'd1, DRAIN=2'd2.
  - The beat layout constants DATA_W=32 and MASK_W=4.
- One natural sub-module: mc_wr_fifo_ptr. It owns the pointer/level/full/empty bookkeeping. The top level holds storage and the burst FSM.

Test Plan:
- Reset, push 4 beats 0x0_11111111..0x0_44444444 → level=4, full=1; burst_rdy=1 with burst_beats=4 two cycles after the 4th push; 4 pops return the beats in order; FSM back to IDLE, empty=1.
- Fill to full, then push 0xF_DEADBEEF with re=0 → ovf=1, level stays 4, entry absent. Repeat with re=1 → push accepted, level stays 4.
- Push 2 beats, flush pulse → burst_rdy=1 with burst_beats=2; pop 2 → IDLE, burst_rdy stays 0.
- Pop while empty with we=1, din=0xA_12345678 → udf=1, level=1, dout=0xA_12345678 next cycle.
- Wrap-around: 10 push/pop pairs interleaved at level 1..3 → data order preserved across pointer wrap, ovf=udf=0.
- clr mid-DRAIN after 1 of 4 pops → next cycle level=0, empty=1, burst_rdy=0, FSM=IDLE, flags 0. Same checks with async rst asserted mid-cycle.
